// File: rtl/register_readback_if.sv
// Bundle of write, read-request and valid/ready output-channel signals for register_readback.
// The design sits on the slave side; the producer/consumer of those signals is the master.
interface register_readback_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_address;
  logic [DATA_WIDTH-1:0] wr_content;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_address;
  logic                  dump_start;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_address;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  busy;

  modport master (
    output wr_en, wr_address, wr_content, rd_req, rd_address, dump_start, out_ready,
    input  out_valid, out_address, out_data, busy
  );

  modport slave (
    input  wr_en, wr_address, wr_content, rd_req, rd_address, dump_start, out_ready,
    output out_valid, out_address, out_data, busy
  );
endinterface

// File: rtl/register_readback.sv
// General-purpose register array with write port and a valid/ready readback channel
// serving single reads and an in-order full-array dump; register 0 reads as zero.
module register_readback #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  register_readback_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SINGLE, DUMP} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic                  out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0] out_address_q, out_address_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0] dump_cnt_q, dump_cnt_d;
  logic [ADDR_WIDTH-1:0] next_dump_addr;
  logic [DATA_WIDTH-1:0] single_value;
  logic [DATA_WIDTH-1:0] next_dump_value;

  // Value of a register as seen at a load edge, forwarding a same-cycle write.
  function automatic logic [DATA_WIDTH-1:0] read_value(input logic [ADDR_WIDTH-1:0] a);
    if (a == '0)
      return '0;
    else if (bus.wr_en && bus.wr_address == a)
      return bus.wr_content;
    else
      return regs_q[a];
  endfunction

  assign next_dump_addr  = dump_cnt_q + 1'b1;
  assign single_value    = read_value(bus.rd_address);
  assign next_dump_value = read_value(next_dump_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (bus.wr_en && bus.wr_address != '0) begin
      regs_q[bus.wr_address] <= bus.wr_content;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      out_valid_q   <= 1'b0;
      out_address_q <= '0;
      out_data_q    <= '0;
      dump_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      out_address_q <= out_address_d;
      out_data_q    <= out_data_d;
      dump_cnt_q    <= dump_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    out_valid_d   = out_valid_q;
    out_address_d = out_address_q;
    out_data_d    = out_data_q;
    dump_cnt_d    = dump_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.dump_start) begin
          state_d       = DUMP;
          out_valid_d   = 1'b1;
          out_address_d = '0;
          out_data_d    = '0;
          dump_cnt_d    = '0;
        end else if (bus.rd_req) begin
          state_d       = SINGLE;
          out_valid_d   = 1'b1;
          out_address_d = bus.rd_address;
          out_data_d    = single_value;
        end
      end
      SINGLE: begin
        if (out_valid_q && bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      DUMP: begin
        // Next entry is loaded on the same edge that retires the current one.
        if (out_valid_q && bus.out_ready) begin
          if (dump_cnt_q == LAST_ADDR) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            dump_cnt_d  = '0;
          end else begin
            dump_cnt_d    = next_dump_addr;
            out_address_d = next_dump_addr;
            out_data_d    = next_dump_value;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_address = out_address_q;
  assign bus.out_data    = out_data_q;
  assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_register_readback.sv
// Randomized self-checking bench for register_readback against a behavioural
// model of the register file and its single-read / dump channel.
module tb_register_readback;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  register_readback_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  register_readback #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Model: register contents plus what the channel should be presenting.
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_mode;      // 0 idle, 1 single read, 2 dump
  logic [36:0] got_q [$];   // handshaken {addr, data} pairs seen on the DUT

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (bus.wr_en && bus.wr_address == a) return bus.wr_content;
    return m_regs[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_valid = 1'b0; m_addr = 5'd0; m_data = 32'h0; m_mode = 0;
  endtask

  task automatic idle_inputs();
    bus.wr_en = 1'b0; bus.wr_address = '0; bus.wr_content = '0;
    bus.rd_req = 1'b0; bus.rd_address = '0; bus.dump_start = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  // Called at a negedge with inputs settled: advance the model across one rising edge.
  task automatic step();
    if (bus.out_valid && bus.out_ready) got_q.push_back({bus.out_address, bus.out_data});
    if (m_mode == 0) begin
      if (bus.dump_start) begin
        m_mode = 2; m_valid = 1'b1; m_addr = 5'd0; m_data = 32'h0;
      end else if (bus.rd_req) begin
        m_mode = 1; m_valid = 1'b1; m_addr = bus.rd_address; m_data = m_read(bus.rd_address);
      end
    end else if (bus.out_ready) begin
      if (m_mode == 1 || m_addr == 5'd31) begin
        m_mode = 0; m_valid = 1'b0;
      end else begin
        m_addr = m_addr + 5'd1; m_data = m_read(m_addr);
      end
    end
    if (bus.wr_en && bus.wr_address != 0) m_regs[bus.wr_address] = bus.wr_content;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    bus.wr_en = 1'b1; bus.wr_address = a; bus.wr_content = d;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    m_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_address !== 5'd0 || bus.out_data !== 32'h0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b addr=%0d data=%h busy=%b, required 0 0 0 0",
               bus.out_valid, bus.out_address, bus.out_data, bus.busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_single_read();
    write_reg(5'd5, 32'hDEADBEEF);
    bus.rd_req = 1'b1; bus.rd_address = 5'd5; bus.out_ready = 1'b1;
    step();
    bus.rd_req = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_address !== 5'd5 || bus.out_data !== 32'hDEADBEEF || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_read: valid=%b addr=%0d data=%h busy=%b, required 1 5 deadbeef 1",
               bus.out_valid, bus.out_address, bus.out_data, bus.busy);
    end
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: valid=%b busy=%b, required 0 0", bus.out_valid, bus.busy);
    end
    $display("single read r5 -> %h", 32'hDEADBEEF);
  endtask

  task automatic test_zero_reg();
    write_reg(5'd0, 32'h12345678);
    bus.rd_req = 1'b1; bus.rd_address = 5'd0; bus.out_ready = 1'b0;
    step();
    bus.rd_req = 1'b0;
    // Stall a few cycles: outputs must hold.
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_address !== 5'd0 || bus.out_data !== 32'h0) begin
        n_fail++;
        $display("FAIL zero_reg: valid=%b addr=%0d data=%h, required 1 0 00000000",
                 bus.out_valid, bus.out_address, bus.out_data);
      end
    end
    bus.out_ready = 1'b1;
    step();
    $display("read r0 after write 12345678 -> 0");
  endtask

  task automatic test_forwarding();
    bus.wr_en = 1'b1; bus.wr_address = 5'd7; bus.wr_content = 32'hA5A5A5A5;
    bus.rd_req = 1'b1; bus.rd_address = 5'd7; bus.out_ready = 1'b0;
    step();
    bus.wr_en = 1'b0; bus.rd_req = 1'b0;
    n_checks++;
    if (bus.out_data !== 32'hA5A5A5A5 || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL forward: valid=%b data=%h, required 1 a5a5a5a5", bus.out_valid, bus.out_data);
    end
    // Overwrite the presented register while stalled: entry must not change.
    write_reg(5'd7, 32'h0BADF00D);
    n_checks++;
    if (bus.out_data !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL frozen_on_write: data=%h, required a5a5a5a5", bus.out_data);
    end
    bus.out_ready = 1'b1;
    step();
    $display("forwarded read r7 -> a5a5a5a5");
  endtask

  task automatic test_dump();
    for (int k = 1; k < 32; k++) write_reg(5'(k), 32'(k * 32'h11));
    got_q.delete();
    bus.dump_start = 1'b1; bus.out_ready = 1'b1;
    step();
    bus.dump_start = 1'b0;
    for (int i = 1; i < 32; i++) step();
    n_checks++;
    if (bus.busy !== 1'b1 || bus.out_address !== 5'd31) begin
      n_fail++;
      $display("FAIL dump_last_entry: busy=%b addr=%0d, required 1 31", bus.busy, bus.out_address);
    end
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL dump_end: valid=%b busy=%b, required 0 0", bus.out_valid, bus.busy);
    end
    n_checks++;
    if (got_q.size() != 32) begin
      n_fail++;
      $display("FAIL dump_count: got %0d entries, required 32", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 32; i++) begin
      n_checks++;
      if (got_q[i] !== {5'(i), 32'(i * 32'h11)}) begin
        n_fail++;
        $display("FAIL dump_entry: index %0d got %h, required %h", i, got_q[i], {5'(i), 32'(i * 32'h11)});
      end
    end
    $display("dump of 32 entries with ready held high");
  endtask

  task automatic test_dump_stall();
    logic [4:0]  prev_addr;
    logic [31:0] prev_data;
    logic        prev_valid;
    int          cycles;
    got_q.delete();
    bus.dump_start = 1'b1; bus.out_ready = 1'b0;
    step();
    bus.dump_start = 1'b0;
    cycles = 0;
    while (m_mode != 0 && cycles < 200) begin
      prev_valid = bus.out_valid; prev_addr = bus.out_address; prev_data = bus.out_data;
      bus.out_ready = cycles[0];
      bus.rd_req = (cycles % 7 == 3); bus.rd_address = 5'($urandom_range(1, 31));
      bus.wr_en = ($urandom_range(0, 1) == 1);
      bus.wr_address = 5'($urandom_range(0, 31)); bus.wr_content = $urandom;
      step();
      n_checks++;
      if (bus.out_valid !== m_valid || bus.busy !== (m_mode != 0) ||
          (m_valid && (bus.out_address !== m_addr || bus.out_data !== m_data))) begin
        n_fail++;
        $display("FAIL dump_stall_cycle: valid=%b addr=%0d data=%h busy=%b, required %b %0d %h %b",
                 bus.out_valid, bus.out_address, bus.out_data, bus.busy, m_valid, m_addr, m_data, m_mode != 0);
      end
      if (!cycles[0] && prev_valid) begin
        n_checks++;
        if (bus.out_address !== prev_addr || bus.out_data !== prev_data) begin
          n_fail++;
          $display("FAIL dump_stall_frozen: addr=%0d data=%h, required %0d %h",
                   bus.out_address, bus.out_data, prev_addr, prev_data);
        end
      end
      cycles++;
    end
    idle_inputs();
    n_checks++;
    if (m_mode != 0 || got_q.size() != 32) begin
      n_fail++;
      $display("FAIL dump_stall_count: got %0d entries in %0d cycles, required 32", got_q.size(), cycles);
    end
    for (int i = 0; i < got_q.size() && i < 32; i++) begin
      n_checks++;
      if (got_q[i][36:32] !== 5'(i)) begin
        n_fail++;
        $display("FAIL dump_stall_order: index %0d addr %0d, required %0d", i, got_q[i][36:32], i);
      end
    end
    $display("stalled dump of %0d entries in %0d cycles", got_q.size(), cycles);
  endtask

  task automatic test_random_traffic();
    for (int c = 0; c < 400; c++) begin
      bus.wr_en = ($urandom_range(0, 2) != 0);
      bus.wr_address = 5'($urandom_range(0, 31)); bus.wr_content = $urandom;
      bus.rd_req = ($urandom_range(0, 2) == 0);
      bus.rd_address = ($urandom_range(0, 1) == 1) ? bus.wr_address : 5'($urandom_range(0, 31));
      bus.dump_start = ($urandom_range(0, 39) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
      n_checks++;
      if (bus.out_valid !== m_valid || bus.busy !== (m_mode != 0) ||
          (m_valid && (bus.out_address !== m_addr || bus.out_data !== m_data))) begin
        n_fail++;
        $display("FAIL random_cycle %0d: valid=%b addr=%0d data=%h busy=%b, required %b %0d %h %b",
                 c, bus.out_valid, bus.out_address, bus.out_data, bus.busy, m_valid, m_addr, m_data, m_mode != 0);
      end
    end
    idle_inputs();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && m_mode != 0; c++) step();
    bus.out_ready = 1'b0;
    $display("random traffic of 400 cycles");
  endtask

  task automatic test_reset_mid_dump();
    for (int k = 1; k < 32; k++) write_reg(5'(k), 32'(k * 32'h11));
    bus.dump_start = 1'b1; bus.out_ready = 1'b1;
    step();
    bus.dump_start = 1'b0;
    for (int i = 0; i < 11; i++) step();
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_address !== 5'd11) begin
      n_fail++;
      $display("FAIL pre_reset_entry: valid=%b addr=%0d, required 1 11", bus.out_valid, bus.out_address);
    end
    rst_n = 1'b0;
    m_reset();
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b busy=%b data=%h, required 0 0 0", bus.out_valid, bus.busy, bus.out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      bus.rd_req = 1'b1; bus.rd_address = 5'($urandom_range(1, 31)); bus.out_ready = 1'b1;
      step();
      bus.rd_req = 1'b0;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0) begin
        n_fail++;
        $display("FAIL read_after_reset: r%0d valid=%b data=%h, required 1 00000000",
                 bus.out_address, bus.out_valid, bus.out_data);
      end
      step();
    end
    $display("reset during dump cleared array and channel");
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_zero_reg();
    test_forwarding();
    test_dump();
    test_dump_stall();
    test_random_traffic();
    test_reset_mid_dump();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/register_readback.md
# register_readback

Read-side companion to the register-file write path: holds the 32 x 32-bit general-purpose register array, accepts writes (address/content/enable), and returns register contents over a valid/ready output channel. It serves single-register reads and a full-array dump (registers 0..31 streamed in order) for the debug/trace path. Register 0 is hardwired to zero (MIPS $zero).

## Interface

- DATA_WIDTH, 32, register width
- ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- wr_en  input  1  write strobe, sampled at clk edge
- wr_address  input  ADDR_WIDTH  write target
- wr_content  input  DATA_WIDTH  write data
- rd_req  input  1  single-read request, sampled at clk edge
- rd_address  input  ADDR_WIDTH  single-read target
- dump_start  input  1  start full-array stream
- out_valid  output  1  out_address/out_data hold a valid entry
- out_ready  input  1  consumer accepts entry when high with out_valid
- out_address  output  ADDR_WIDTH  address of presented entry
- out_data  output  DATA_WIDTH  content of presented entry
- busy  output  1  high whenever state != IDLE

## Operation

- Reset (rst_n low, asynchronous): all registers cleared to 0; state IDLE; out_valid 0, out_address 0, out_data 0, busy 0; dump counter 0.
- Write: wr_en high at an edge stores wr_content at wr_address; write to address 0 ignored. Writes are accepted in every state.
- Read value of address A at load time: 0 if A == 0; else wr_content if wr_en and wr_address == A in the same cycle (write-through forwarding); else stored value.
- States: IDLE, SINGLE, DUMP.
- IDLE: dump_start -> load entry 0, out_valid 1, go DUMP. Else rd_req -> load entry rd_address, out_valid 1, go SINGLE. dump_start wins if both high.
- SINGLE: entry held stable until out_valid & out_ready at an edge; then out_valid 0, go IDLE.
- DUMP: on handshake for address i < 31, load entry i+1 in the same edge (out_valid stays 1); on handshake for address 31, out_valid 0, counter 0, go IDLE.
- rd_req and dump_start ignored when not IDLE (no queuing).
- Without handshake, out_address/out_data never change while out_valid is 1, even if the presented register is written; the new value is seen only on a later read.
- A dump entry is read at its load edge, so writes to not-yet-streamed registers during a dump are reflected.
- Counter width ADDR_WIDTH; no wrap past 31, dump terminates there.

## Timing

- Single-read latency: rd_req sampled at edge N -> out_valid 1 after edge N; with out_ready held high, handshake at edge N+1, back in IDLE after N+1. Next request accepted at edge N+2.
- Dump throughput: one entry per cycle with out_ready held high; 32 entries occupy edges N+1..N+32 after dump_start at edge N; busy falls after edge N+32.
- out_ready low stalls indefinitely with outputs frozen.
- Reset asserted mid-SINGLE or mid-DUMP: immediate return to reset values; no further entries; array cleared.
- out_* are registered; no combinational path from inputs to outputs.

## Test plan

- Reset, write 0xDEADBEEF to r5, rd_req r5 with out_ready 1 -> out_valid 1 one cycle later, out_address 5, out_data 0xDEADBEEF, busy falls after handshake.
- Write 0x12345678 to r0, read r0 -> out_data 0x00000000.
- Same-cycle wr_en r7 = 0xA5A5A5A5 and rd_req r7 (prior 0) -> out_data 0xA5A5A5A5.
- Write rK = K*0x11 for K=1..31, dump_start with out_ready 1 -> 32 consecutive handshakes, addresses 0..31, data 0, 0x11, ..., 0x20F, then out_valid 0, busy 0.
- Dump with out_ready toggling 1/0 each cycle and rd_req pulsed mid-dump -> outputs frozen while ready 0, no lost or duplicated entries, rd_req ignored, 32 entries total.
- Assert rst_n low after entry 10 of a dump -> out_valid 0, busy 0 immediately; subsequent read of any previously written register returns 0.
